// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operation sequencer: funct codes, ALU select
// fields, sequencer states and the decoded control bundle.
package alu_seq_pkg;

    localparam logic [4:0] FN_ADD   = 5'h00;
    localparam logic [4:0] FN_COMP  = 5'h01;
    localparam logic [4:0] FN_AND   = 5'h02;
    localparam logic [4:0] FN_XOR   = 5'h03;
    localparam logic [4:0] FN_DIFF  = 5'h04;
    localparam logic [4:0] FN_SUB   = 5'h05;
    localparam logic [4:0] FN_SHLL  = 5'h06;
    localparam logic [4:0] FN_SHRL  = 5'h07;
    localparam logic [4:0] FN_SHRA  = 5'h08;
    localparam logic [4:0] FN_SHLLV = 5'h09;
    localparam logic [4:0] FN_SHRLV = 5'h0A;
    localparam logic [4:0] FN_SHRAV = 5'h0B;

    typedef enum logic [1:0] {
        PSEL_ADD  = 2'b00,
        PSEL_AND  = 2'b01,
        PSEL_XOR  = 2'b10,
        PSEL_DIFF = 2'b11
    } prim_sel_e;

    typedef enum logic [1:0] {
        SHT_SLL = 2'b00,
        SHT_SRL = 2'b01,
        SHT_SRA = 2'b10
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic        a_zero;
        prim_sel_e   primary_sel;
        logic        b_inv;
        shift_type_e shift_type;
        logic        shift_enbl;
        logic [4:0]  shift_amnt;
        logic        legal;
        logic        carry_upd;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational funct decoder: maps an operation code and shift sources to the
// ALU control bundle plus legality and carry-update qualifiers.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] i_funct,
    input  logic [4:0] i_shamt,
    input  logic [4:0] i_rt_amnt,
    output alu_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl             = '0;
        o_ctrl.primary_sel = PSEL_ADD;
        o_ctrl.shift_type  = SHT_SLL;
        case (i_funct)
            FN_ADD: begin
                o_ctrl.legal     = 1'b1;
                o_ctrl.carry_upd = 1'b1;
            end
            // COMP evaluates 0 - rt through the adder
            FN_COMP: begin
                o_ctrl.legal     = 1'b1;
                o_ctrl.carry_upd = 1'b1;
                o_ctrl.a_zero    = 1'b1;
                o_ctrl.b_inv     = 1'b1;
            end
            FN_AND: begin
                o_ctrl.legal       = 1'b1;
                o_ctrl.primary_sel = PSEL_AND;
            end
            FN_XOR: begin
                o_ctrl.legal       = 1'b1;
                o_ctrl.primary_sel = PSEL_XOR;
            end
            FN_DIFF: begin
                o_ctrl.legal       = 1'b1;
                o_ctrl.primary_sel = PSEL_DIFF;
            end
            FN_SUB: begin
                o_ctrl.legal     = 1'b1;
                o_ctrl.carry_upd = 1'b1;
                o_ctrl.b_inv     = 1'b1;
            end
            FN_SHLL, FN_SHLLV: begin
                o_ctrl.legal      = 1'b1;
                o_ctrl.shift_enbl = 1'b1;
                o_ctrl.shift_type = SHT_SLL;
                o_ctrl.shift_amnt = (i_funct == FN_SHLL) ? i_shamt : i_rt_amnt;
            end
            FN_SHRL, FN_SHRLV: begin
                o_ctrl.legal      = 1'b1;
                o_ctrl.shift_enbl = 1'b1;
                o_ctrl.shift_type = SHT_SRL;
                o_ctrl.shift_amnt = (i_funct == FN_SHRL) ? i_shamt : i_rt_amnt;
            end
            FN_SHRA, FN_SHRAV: begin
                o_ctrl.legal      = 1'b1;
                o_ctrl.shift_enbl = 1'b1;
                o_ctrl.shift_type = SHT_SRA;
                o_ctrl.shift_amnt = (i_funct == FN_SHRA) ? i_shamt : i_rt_amnt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-issue ALU operation sequencer: accepts an op, drives the external ALU
// for one cycle, captures result and flags, and holds the result until taken.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_funct,
    input  logic [4:0]  issue_shamt,
    input  logic [31:0] issue_rs,
    input  logic [31:0] issue_rt,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_addr_src_b_sel,
    output logic [1:0]  alu_primary_sel,
    output logic [1:0]  alu_shift_type,
    output logic [4:0]  alu_shift_amnt,
    output logic        alu_shift_enbl,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_msb,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        flag_c,
    output logic        flag_s,
    output logic        flag_z
);

    // state | meaning
    // IDLE  | no op held, ready to accept
    // EXEC  | ALU driven from latched op, result captured at cycle end
    // DONE  | result presented, waiting for res_ready

    state_e      r_state;
    state_e      w_state_nxt;
    logic [4:0]  r_funct;
    logic [4:0]  r_shamt;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] r_res_data;
    logic        r_res_err;
    logic        r_flag_c;
    logic        r_flag_s;
    logic        r_flag_z;
    alu_ctrl_t   w_ctrl;
    logic        w_exec;
    logic        w_issue_ready;
    logic        w_accept;

    alu_op_decode u_decode (
        .i_funct   (r_funct),
        .i_shamt   (r_shamt),
        .i_rt_amnt (r_rt[4:0]),
        .o_ctrl    (w_ctrl)
    );

    assign w_exec        = (r_state == ST_EXEC);
    assign w_issue_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && res_ready);
    // flush wins over a simultaneous accept
    assign w_accept      = issue_valid && w_issue_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
                ST_EXEC: w_state_nxt = ST_DONE;
                ST_DONE: if (res_ready) w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct    <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_s   <= 1'b0;
            r_flag_z   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct   <= issue_funct;
                r_shamt   <= issue_shamt;
                r_rs      <= issue_rs;
                r_rt      <= issue_rt;
                r_res_err <= 1'b0;
            end
            if (w_exec && !flush) begin
                if (w_ctrl.legal) begin
                    r_res_data <= alu_result;
                    r_res_err  <= 1'b0;
                    r_flag_z   <= alu_zero;
                    r_flag_s   <= alu_msb;
                    if (w_ctrl.carry_upd) r_flag_c <= alu_cout;
                end else begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end
            end
        end
    end

    // operands hold their latched values; controls are live only in EXEC
    always_comb begin
        alu_a              = r_rs;
        alu_b              = r_rt;
        alu_addr_src_b_sel = 1'b0;
        alu_primary_sel    = 2'b00;
        alu_shift_type     = 2'b00;
        alu_shift_amnt     = 5'd0;
        alu_shift_enbl     = 1'b0;
        if (w_exec) begin
            if (w_ctrl.a_zero) alu_a = '0;
            alu_addr_src_b_sel = w_ctrl.b_inv;
            alu_primary_sel    = w_ctrl.primary_sel;
            alu_shift_type     = w_ctrl.shift_type;
            alu_shift_amnt     = w_ctrl.shift_amnt;
            alu_shift_enbl     = w_ctrl.shift_enbl;
        end
    end

    assign issue_ready = w_issue_ready;
    assign res_valid   = (r_state == ST_DONE);
    assign res_data    = r_res_data;
    assign res_err     = r_res_err;
    assign flag_c      = r_flag_c;
    assign flag_s      = r_flag_s;
    assign flag_z      = r_flag_z;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: behavioural ALU, arithmetic reference
// model, and an independent result monitor.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_funct;
    logic [4:0]  issue_shamt;
    logic [31:0] issue_rs;
    logic [31:0] issue_rt;
    logic        flush;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_addr_src_b_sel;
    logic [1:0]  alu_primary_sel;
    logic [1:0]  alu_shift_type;
    logic [4:0]  alu_shift_amnt;
    logic        alu_shift_enbl;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_msb;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic        flag_c;
    logic        flag_s;
    logic        flag_z;

    alu_op_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_funct        (issue_funct),
        .issue_shamt        (issue_shamt),
        .issue_rs           (issue_rs),
        .issue_rt           (issue_rt),
        .flush              (flush),
        .alu_a              (alu_a),
        .alu_b              (alu_b),
        .alu_addr_src_b_sel (alu_addr_src_b_sel),
        .alu_primary_sel    (alu_primary_sel),
        .alu_shift_type     (alu_shift_type),
        .alu_shift_amnt     (alu_shift_amnt),
        .alu_shift_enbl     (alu_shift_enbl),
        .alu_result         (alu_result),
        .alu_cout           (alu_cout),
        .alu_msb            (alu_msb),
        .alu_zero           (alu_zero),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .res_err            (res_err),
        .flag_c             (flag_c),
        .flag_s             (flag_s),
        .flag_z             (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        c;
        logic        s;
        logic        z;
        int          first_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   rr_mode = 0;
    logic m_c = 1'b0;
    logic m_s = 1'b0;
    logic m_z = 1'b0;
    logic acc_in_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural external ALU; DIFF is taken to be the unsigned absolute difference
    logic [31:0] bop;
    logic [32:0] asum;
    logic [31:0] ares;
    always_comb begin
        bop  = alu_addr_src_b_sel ? ~alu_b : alu_b;
        asum = {1'b0, alu_a} + {1'b0, bop} + {32'd0, alu_addr_src_b_sel};
        ares = '0;
        case (alu_primary_sel)
            2'b00:   ares = asum[31:0];
            2'b01:   ares = alu_a & alu_b;
            2'b10:   ares = alu_a ^ alu_b;
            default: ares = (alu_a >= alu_b) ? alu_a - alu_b : alu_b - alu_a;
        endcase
        if (alu_shift_enbl) begin
            case (alu_shift_type)
                2'b00:   ares = alu_a << alu_shift_amnt;
                2'b01:   ares = alu_a >> alu_shift_amnt;
                default: ares = 32'($signed(alu_a) >>> alu_shift_amnt);
            endcase
        end
        alu_result = ares;
        alu_cout   = asum[32];
        alu_msb    = ares[31];
        alu_zero   = (ares == 32'd0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic [4:0] f, input logic [4:0] sh,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] wide;
        logic [31:0] res;
        logic        legal;
        logic        cnew;
        legal = 1'b1;
        cnew  = m_c;
        res   = '0;
        wide  = '0;
        case (f)
            5'h00: begin wide = {1'b0, a} + {1'b0, b}; res = wide[31:0]; cnew = wide[32]; end
            5'h01: begin res = 32'd0 - b; cnew = (b == 32'd0); end
            5'h02: res = a & b;
            5'h03: res = a ^ b;
            5'h04: res = (a >= b) ? a - b : b - a;
            5'h05: begin res = a - b; cnew = (a >= b); end
            5'h06: res = a << sh;
            5'h07: res = a >> sh;
            5'h08: res = 32'($signed(a) >>> sh);
            5'h09: res = a << b[4:0];
            5'h0A: res = a >> b[4:0];
            5'h0B: res = 32'($signed(a) >>> b[4:0]);
            default: legal = 1'b0;
        endcase
        if (legal) begin
            m_c = cnew;
            m_s = res[31];
            m_z = (res == 32'd0);
        end
        e.data      = legal ? res : 32'd0;
        e.err       = !legal;
        e.c         = m_c;
        e.s         = m_s;
        e.z         = m_z;
        e.first_cyc = 0;
        return e;
    endfunction

    task automatic check_ctrl(input logic [4:0] f, input logic [4:0] sh,
                              input logic [31:0] a, input logic [31:0] b);
        logic [1:0] psel;
        logic [1:0] typ;
        if (f > 5'h0B) return;
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_a", alu_a, (f == 5'h01) ? 32'd0 : a);
        chk("exec_b_sel", 32'(alu_addr_src_b_sel), 32'((f == 5'h01) || (f == 5'h05)));
        chk("exec_shift_enbl", 32'(alu_shift_enbl), 32'(f >= 5'h06));
        if (f < 5'h06) begin
            psel = (f == 5'h02) ? 2'b01 : (f == 5'h03) ? 2'b10 : (f == 5'h04) ? 2'b11 : 2'b00;
            chk("exec_primary_sel", 32'(alu_primary_sel), 32'(psel));
        end else begin
            typ = (f == 5'h06 || f == 5'h09) ? 2'b00 : (f == 5'h07 || f == 5'h0A) ? 2'b01 : 2'b10;
            chk("exec_shift_type", 32'(alu_shift_type), 32'(typ));
            chk("exec_shift_amnt", 32'(alu_shift_amnt), 32'((f < 5'h09) ? sh : b[4:0]));
        end
    endtask

    // kill: 0 normal, 1 flush during EXEC, 2 reset during EXEC
    task automatic issue(input logic [4:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input int kill);
        exp_t e;
        int   n;
        issue_valid = 1'b1;
        issue_funct = f;
        issue_shamt = sh;
        issue_rs    = a;
        issue_rt    = b;
        n = 0;
        while (!issue_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!issue_ready) begin
            n_vec++;
            n_mis++;
            $display("FAIL issue_timeout: issue_ready stayed 0 for funct %h", f);
            issue_valid = 1'b0;
            return;
        end
        acc_in_done = res_valid;
        if (kill == 0) begin
            e = ref_op(f, sh, a, b);
            e.first_cyc = cyc + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        check_ctrl(f, sh, a, b);
        if (kill == 1) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end else if (kill == 2) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
            chk("rst_mid_flags", 32'({flag_c, flag_s, flag_z}), 32'd0);
            m_c = 1'b0;
            m_s = 1'b0;
            m_z = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_release_issue_ready", 32'(issue_ready), 32'd1);
        end
    endtask

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 2) != 0);
                default: res_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        prev_v;
        logic        held;
        logic [31:0] hd;
        logic        he;
        prev_v = 1'b0;
        held   = 1'b0;
        hd     = '0;
        he     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                held   = 1'b0;
            end else begin
                if (res_valid) begin
                    if (!prev_v) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_mis++;
                            $display("FAIL unexpected_result: data %h err %b with no op pending", res_data, res_err);
                        end else begin
                            chk("result_latency_cycle", 32'(cyc), 32'(sb[0].first_cyc));
                        end
                    end else if (held) begin
                        chk("stall_data_stable", res_data, hd);
                        chk("stall_err_stable", 32'(res_err), 32'(he));
                    end
                    if (res_ready) begin
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("res_data", res_data, e.data);
                            chk("res_err", 32'(res_err), 32'(e.err));
                            chk("flags_csz", 32'({flag_c, flag_s, flag_z}), 32'({e.c, e.s, e.z}));
                        end
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        hd   = res_data;
                        he   = res_err;
                    end
                end else begin
                    held = 1'b0;
                end
                prev_v = res_valid;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_funct = '0;
        issue_shamt = '0;
        issue_rs    = '0;
        issue_rt    = '0;
        flush       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_s, flag_z}), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'({alu_addr_src_b_sel, alu_primary_sel, alu_shift_type,
                                 alu_shift_amnt, alu_shift_enbl}), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(5'h05, 5'd0, 32'd5, 32'd7, 0);
        issue(5'h00, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        issue(5'h0B, 5'd17, 32'h8000_0000, 32'h0000_0004, 0);
        issue(5'h01, 5'd0, 32'h0, 32'h0000_0003, 0);
        issue(5'h04, 5'd0, 32'd3, 32'd10, 0);

        repeat (4) @(negedge clk);
        rr_mode = 2;
        issue(5'h03, 5'd0, $urandom, $urandom, 0);
        repeat (4) @(negedge clk);
        chk("stall_res_valid_held", 32'(res_valid), 32'd1);
        rr_mode = 0;
        issue(5'h02, 5'd0, $urandom, $urandom, 0);
        chk("b2b_accept_in_done", 32'(acc_in_done), 32'd1);
        issue(5'h00, 5'd0, $urandom, $urandom, 0);
        chk("b2b_second_accept_in_done", 32'(acc_in_done), 32'd1);

        issue(5'h1F, 5'd3, $urandom, $urandom, 0);
        issue(5'h0C, 5'd0, $urandom, $urandom, 0);
        issue(5'h00, 5'd0, $urandom, $urandom, 1);
        repeat (4) @(negedge clk);
        chk("flush_idle_ready", 32'(issue_ready), 32'd1);

        issue_valid = 1'b1;
        issue_funct = 5'h00;
        issue_rs    = 32'h1234_5678;
        issue_rt    = 32'h1;
        flush       = 1'b1;
        @(negedge clk);
        flush       = 1'b0;
        issue_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_beats_accept", 32'(res_valid), 32'd0);

        issue(5'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 0);
        issue(5'h05, 5'd0, 32'd9, 32'd2, 2);
        repeat (3) @(negedge clk);

        rr_mode = 1;
        for (int i = 0; i < 200; i++) begin
            f = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
            case ($urandom_range(0, 5))
                0:       a = 32'h0;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 5) == 0) ? a : $urandom;
            issue(f, 5'($urandom_range(0, 31)), a, b, ($urandom_range(0, 15) == 0) ? 1 : 0);
        end

        rr_mode = 0;
        issue_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 issue_valid  in  1  operation offered; issue_ready  out  1  sequencer can accept.
REQ-004 issue_funct  in  5  operation code; issue_shamt  in  5  immediate shift amount.
REQ-005 issue_rs, issue_rt  in  32  operands (rs = A, rt = B / variable shift amount).
REQ-006 flush  in  1  synchronous abort of the in-flight op.
REQ-007 alu_a, alu_b  out  32  operands to the ALU.
REQ-008 alu_addr_src_b_sel  out  1  invert B and set carry-in.
REQ-009 alu_primary_sel  out  2  00 add, 01 and, 10 xor, 11 diff.
REQ-010 alu_shift_type  out  2  00 sll, 01 srl, 10 sra.
REQ-011 alu_shift_amnt  out  5; alu_shift_enbl  out  1.
REQ-012 alu_result  in  32; alu_cout, alu_msb, alu_zero  in  1  ALU outputs, combinational.
REQ-013 res_valid  out  1; res_ready  in  1; res_data  out  32; res_err  out  1  illegal funct.
REQ-014 flag_c, flag_s, flag_z  out  1  architectural carry/sign/zero flags.

Function
REQ-015 Funct codes: ADD 00, COMP 01, AND 02, XOR 03, DIFF 04, SUB 05, SHLL 06, SHRL 07, SHRA 08, SHLLV 09, SHRLV 0A, SHRAV 0B; all others illegal.
REQ-016 FSM states IDLE, EXEC, DONE; issue_ready = (state==IDLE) or (state==DONE and res_ready).
REQ-017 Accept (issue_valid & issue_ready) latches funct, shamt, rs, rt and enters EXEC.
REQ-018 In EXEC, ALU controls shall be decoded from latched funct; outside EXEC all control outputs 0, alu_a/alu_b hold latched values.
REQ-019 ADD: sel 00, b_sel 0; SUB: sel 00, b_sel 1 (A + ~B + 1); COMP: alu_a = 0, alu_b = rt, sel 00, b_sel 1.
REQ-020 Shifts: shift_enbl 1, alu_a = rs; amount = shamt for SHLL/SHRL/SHRA, rt[4:0] for variable forms; amount 0 yields rs unchanged.
REQ-021 EXEC lasts exactly one cycle; res_data captures alu_result (0 if illegal), state goes to DONE, res_valid = 1 on the next cycle (latency 2 cycles from accept).
REQ-022 res_data/res_err shall remain stable while res_valid=1 and res_ready=0.
REQ-023 DONE: res_ready=1 with issue_valid=1 -> EXEC (back-to-back); res_ready=1 without issue_valid -> IDLE.
REQ-024 Flags update at EXEC end for legal ops only: flag_z, flag_s from alu_zero, alu_msb; flag_c from alu_cout only for ADD/SUB/COMP, otherwise retained.
REQ-025 Illegal funct: res_err=1, res_data=0, flags unchanged; res_err cleared on the next accept.
REQ-026 flush (any state) -> IDLE next cycle, res_valid=0, in-flight result discarded, flags retained; flush outranks accept in the same cycle.

Reset
REQ-027 rst_n low asynchronously forces IDLE, res_valid=0, res_data=0, res_err=0, all flags 0, all ALU outputs 0.
REQ-028 Reset mid-operation discards the op with no res_valid pulse; issue_ready=1 in the first cycle after release.

Structure
REQ-029 Package alu_seq_pkg holds funct codes, primary_sel and shift_type encodings, and the state enum.
REQ-030 Sub-module alu_op_decode: combinational funct/shamt/rt -> ALU control bundle and legal/carry-update flags.

Verification
REQ-031 Reset asserted mid-EXEC -> res_valid stays 0, flags 000, issue_ready=1 after release.
REQ-032 ADD rs=FFFFFFFF rt=00000001 -> res_data 00000000, c=1 z=1 s=0, res_valid 2 cycles after accept.
REQ-033 SUB rs=5 rt=7 -> alu_addr_src_b_sel=1 in EXEC, res_data FFFFFFFE, s=1 c=0 z=0.
REQ-034 SHRAV rs=80000000 rt=00000004 with c=1 beforehand -> shift_type 10, amnt 4, enbl 1, res_data F8000000, c stays 1.
REQ-035 res_ready low 3 cycles -> res_data stable; raise res_ready with issue_valid -> next op accepted same cycle, back-to-back results.
REQ-036 funct 1F -> res_err=1, res_data 0, flags unchanged; flush during EXEC -> IDLE, no res_valid.
